// File: rtl/control_step_sequencer.sv
// Hardwired control-step sequencer: one-hot T-steps plus datapath strobes for fetch and
// ALU-reg/imm, ld, st, halt execution, with memory-handshake stalls and a bus timeout.
module control_step_sequencer #(
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic                 i_run,
  input  logic [OPC_W-1:0]     i_ir_opcode,
  input  logic                 i_mem_ready,
  output logic [NUM_STEPS-1:0] o_step,
  output logic                 o_pc_out,
  output logic                 o_zlow_out,
  output logic                 o_mdr_out,
  output logic                 o_c_out,
  output logic                 o_r_out,
  output logic                 o_mar_in,
  output logic                 o_pc_in,
  output logic                 o_mdr_in,
  output logic                 o_ir_in,
  output logic                 o_y_in,
  output logic                 o_z_in,
  output logic                 o_r_in,
  output logic                 o_inc_pc,
  output logic                 o_read,
  output logic                 o_write,
  output logic                 o_gra,
  output logic                 o_grb,
  output logic                 o_grc,
  output logic [3:0]           o_alu_op,
  output logic                 o_busy,
  output logic                 o_instr_done,
  output logic                 o_illegal,
  output logic                 o_halted,
  output logic                 o_bus_err
);

  if (NUM_STEPS < 8) begin : g_num_steps_check
    $error("control_step_sequencer: NUM_STEPS must be >= 8");
  end

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(MEM_TIMEOUT);

  localparam logic [OPC_W-1:0] OpLd   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OpSt   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OpAdd  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OpSub  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OpAnd  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OpOr   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OpAddi = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OpAndi = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OpOri  = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OpHalt = OPC_W'(5'b11011);

  localparam logic [3:0] AluNone = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0001;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
  } state_e;

  typedef enum logic [2:0] {ClsReg, ClsImm, ClsLd, ClsSt, ClsHalt, ClsBad} cls_e;

  state_e          r_state;
  state_e          w_state_next;
  state_e          w_after;
  logic [CntW-1:0] r_wait_cnt;
  logic [CntW-1:0] w_wait_cnt_next;
  logic [CntW-1:0] w_wait_cnt_inc;
  logic            r_bus_err;
  logic            w_stalled;
  logic            w_timeout;
  cls_e            w_cls;
  logic [3:0]      w_alu_sel;
  logic [2:0]      w_step_idx;
  logic            w_busy;

  always_comb begin
    w_cls     = ClsBad;
    w_alu_sel = AluNone;
    case (i_ir_opcode)
      OpLd:    begin w_cls = ClsLd;   w_alu_sel = AluAdd; end
      OpSt:    begin w_cls = ClsSt;   w_alu_sel = AluAdd; end
      OpAdd:   begin w_cls = ClsReg;  w_alu_sel = AluAdd; end
      OpSub:   begin w_cls = ClsReg;  w_alu_sel = AluSub; end
      OpAnd:   begin w_cls = ClsReg;  w_alu_sel = AluAnd; end
      OpOr:    begin w_cls = ClsReg;  w_alu_sel = AluOr;  end
      OpAddi:  begin w_cls = ClsImm;  w_alu_sel = AluAdd; end
      OpAndi:  begin w_cls = ClsImm;  w_alu_sel = AluAnd; end
      OpOri:   begin w_cls = ClsImm;  w_alu_sel = AluOr;  end
      OpHalt:  begin w_cls = ClsHalt; end
      default: begin w_cls = ClsBad;  end
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_step_idx = 3'd0;
    case (r_state)
      StT0:    w_step_idx = 3'd0;
      StT1:    w_step_idx = 3'd1;
      StT2:    w_step_idx = 3'd2;
      StT3:    w_step_idx = 3'd3;
      StT4:    w_step_idx = 3'd4;
      StT5:    w_step_idx = 3'd5;
      StT6:    w_step_idx = 3'd6;
      StT7:    w_step_idx = 3'd7;
      default: w_busy     = 1'b0;
    endcase
  end

  assign o_step = w_busy ? (NUM_STEPS'(1) << w_step_idx) : '0;

  // The timeout fires on the stalled cycle that would bring the count up to MEM_TIMEOUT.
  assign w_wait_cnt_inc = r_wait_cnt + 1'b1;
  assign w_timeout      = (w_wait_cnt_inc == TimeoutCnt);
  assign w_after        = i_run ? StT0 : StIdle;

  always_comb begin
    w_state_next = r_state;
    w_stalled    = 1'b0;
    unique case (r_state)
      StIdle: if (i_run) w_state_next = StT0;
      StT0:   w_state_next = StT1;
      StT1: begin
        if (i_mem_ready) w_state_next = StT2;
        else             w_stalled    = 1'b1;
      end
      StT2:   w_state_next = StT3;
      StT3: begin
        case (w_cls)
          ClsHalt: w_state_next = StHalted;
          ClsBad:  w_state_next = w_after;
          default: w_state_next = StT4;
        endcase
      end
      StT4:   w_state_next = StT5;
      StT5: begin
        if (w_cls == ClsLd || w_cls == ClsSt) w_state_next = StT6;
        else                                  w_state_next = w_after;
      end
      StT6: begin
        if (w_cls == ClsLd && !i_mem_ready) w_stalled    = 1'b1;
        else                                w_state_next = StT7;
      end
      StT7: begin
        if (w_cls == ClsSt && !i_mem_ready) w_stalled    = 1'b1;
        else                                w_state_next = w_after;
      end
      StHalted: w_state_next = StHalted;
    endcase
    if (w_stalled && w_timeout) w_state_next = StHalted;
  end

  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (w_state_next != r_state) w_wait_cnt_next = '0;
    else if (w_stalled)          w_wait_cnt_next = w_wait_cnt_inc;
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_stalled && w_timeout) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    o_pc_out     = 1'b0;
    o_zlow_out   = 1'b0;
    o_mdr_out    = 1'b0;
    o_c_out      = 1'b0;
    o_r_out      = 1'b0;
    o_mar_in     = 1'b0;
    o_pc_in      = 1'b0;
    o_mdr_in     = 1'b0;
    o_ir_in      = 1'b0;
    o_y_in       = 1'b0;
    o_z_in       = 1'b0;
    o_r_in       = 1'b0;
    o_inc_pc     = 1'b0;
    o_read       = 1'b0;
    o_write      = 1'b0;
    o_gra        = 1'b0;
    o_grb        = 1'b0;
    o_grc        = 1'b0;
    o_alu_op     = AluNone;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;
    o_halted     = 1'b0;
    unique case (r_state)
      StIdle: ;
      StT0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_z_in   = 1'b1;
      end
      StT1: begin
        o_zlow_out = 1'b1;
        o_pc_in    = (r_wait_cnt == '0);
        o_read     = 1'b1;
        o_mdr_in   = 1'b1;
      end
      StT2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      StT3: begin
        case (w_cls)
          ClsHalt: o_instr_done = 1'b1;
          ClsBad: begin
            o_illegal    = 1'b1;
            o_instr_done = 1'b1;
          end
          default: begin
            o_grb   = 1'b1;
            o_r_out = 1'b1;
            o_y_in  = 1'b1;
          end
        endcase
      end
      StT4: begin
        case (w_cls)
          ClsReg: begin
            o_grc    = 1'b1;
            o_r_out  = 1'b1;
            o_alu_op = w_alu_sel;
            o_z_in   = 1'b1;
          end
          ClsImm, ClsLd, ClsSt: begin
            o_c_out  = 1'b1;
            o_alu_op = w_alu_sel;
            o_z_in   = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        case (w_cls)
          ClsLd, ClsSt: begin
            o_zlow_out = 1'b1;
            o_mar_in   = 1'b1;
          end
          ClsReg, ClsImm: begin
            o_zlow_out   = 1'b1;
            o_gra        = 1'b1;
            o_r_in       = 1'b1;
            o_instr_done = 1'b1;
          end
          default: o_instr_done = 1'b1;
        endcase
      end
      StT6: begin
        o_mdr_in = 1'b1;
        if (w_cls == ClsLd) begin
          o_read = 1'b1;
        end else begin
          o_gra   = 1'b1;
          o_r_out = 1'b1;
        end
      end
      StT7: begin
        if (w_cls == ClsSt) begin
          o_write      = 1'b1;
          o_instr_done = i_mem_ready;
        end else begin
          o_mdr_out    = 1'b1;
          o_gra        = 1'b1;
          o_r_in       = 1'b1;
          o_instr_done = 1'b1;
        end
      end
      StHalted: o_halted = 1'b1;
    endcase
  end

  assign o_busy    = w_busy;
  assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Scoreboard bench for control_step_sequencer: a per-cycle instruction-level reference model
// queues expected outputs; a negedge monitor pops and compares against the DUT.
module tb_control_step_sequencer;

  localparam int MemTimeout = 15;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpHalt = 5'b11011;
  localparam logic [4:0] OpBad  = 5'b11111;

  // Strobe bit positions follow the order of the packed comparison vector.
  localparam logic [17:0] SPcOut   = 18'h20000;
  localparam logic [17:0] SZlowOut = 18'h10000;
  localparam logic [17:0] SMdrOut  = 18'h08000;
  localparam logic [17:0] SCOut    = 18'h04000;
  localparam logic [17:0] SROut    = 18'h02000;
  localparam logic [17:0] SMarIn   = 18'h01000;
  localparam logic [17:0] SPcIn    = 18'h00800;
  localparam logic [17:0] SMdrIn   = 18'h00400;
  localparam logic [17:0] SIrIn    = 18'h00200;
  localparam logic [17:0] SYIn     = 18'h00100;
  localparam logic [17:0] SZIn     = 18'h00080;
  localparam logic [17:0] SRIn     = 18'h00040;
  localparam logic [17:0] SIncPc   = 18'h00020;
  localparam logic [17:0] SRead    = 18'h00010;
  localparam logic [17:0] SWrite   = 18'h00008;
  localparam logic [17:0] SGra     = 18'h00004;
  localparam logic [17:0] SGrb     = 18'h00002;
  localparam logic [17:0] SGrc     = 18'h00001;

  localparam int ClsReg = 0, ClsImm = 1, ClsLd = 2, ClsSt = 3, ClsHalt = 4, ClsBad = 5;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic run = 1'b0;
  logic mem_ready = 1'b0;
  logic [4:0] opc = 5'b0;

  logic [7:0] step;
  logic pc_out, zlow_out, mdr_out, c_out, r_out, mar_in, pc_in, mdr_in, ir_in;
  logic y_in, z_in, r_in, inc_pc, rd, wr, gra, grb, grc;
  logic [3:0] alu_op;
  logic busy, instr_done, illegal, halted, bus_err;

  always #5 clk = ~clk;

  control_step_sequencer #(
    .NUM_STEPS  (8),
    .OPC_W      (5),
    .MEM_TIMEOUT(MemTimeout)
  ) dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_run       (run),
    .i_ir_opcode (opc),
    .i_mem_ready (mem_ready),
    .o_step      (step),
    .o_pc_out    (pc_out),
    .o_zlow_out  (zlow_out),
    .o_mdr_out   (mdr_out),
    .o_c_out     (c_out),
    .o_r_out     (r_out),
    .o_mar_in    (mar_in),
    .o_pc_in     (pc_in),
    .o_mdr_in    (mdr_in),
    .o_ir_in     (ir_in),
    .o_y_in      (y_in),
    .o_z_in      (z_in),
    .o_r_in      (r_in),
    .o_inc_pc    (inc_pc),
    .o_read      (rd),
    .o_write     (wr),
    .o_gra       (gra),
    .o_grb       (grb),
    .o_grc       (grc),
    .o_alu_op    (alu_op),
    .o_busy      (busy),
    .o_instr_done(instr_done),
    .o_illegal   (illegal),
    .o_halted    (halted),
    .o_bus_err   (bus_err)
  );

  logic [34:0] dut_vec;
  assign dut_vec = {step, pc_out, zlow_out, mdr_out, c_out, r_out, mar_in, pc_in, mdr_in,
                    ir_in, y_in, z_in, r_in, inc_pc, rd, wr, gra, grb, grc, alu_op,
                    busy, instr_done, illegal, halted, bus_err};

  typedef struct packed {
    logic [34:0] vec;
    logic [7:0]  phase;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  logic [7:0] phase = 8'd0;

  // Reference model: mode 0 idle, 1 running an instruction, 2 halted.
  int m_mode = 0;
  int m_t = 0;
  int m_stall = 0;
  bit m_berr = 1'b0;

  function automatic string phase_name(logic [7:0] p);
    case (p)
      8'd0: return "reset";
      8'd1: return "addi";
      8'd2: return "fetch_stall";
      8'd3: return "ld_stall";
      8'd4: return "st_stall";
      8'd5: return "illegal";
      8'd6: return "run_drop";
      8'd7: return "halt";
      8'd8: return "timeout";
      8'd9: return "clr_mid_t4";
      default: return "random";
    endcase
  endfunction

  function automatic int cls_of(logic [4:0] o);
    case (o)
      5'b00000: return ClsLd;
      5'b00010: return ClsSt;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return ClsReg;
      5'b01100, 5'b01101, 5'b01110: return ClsImm;
      5'b11011: return ClsHalt;
      default: return ClsBad;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(logic [4:0] o);
    case (o)
      5'b00000, 5'b00010, 5'b00011, 5'b01100: return 4'b0001;
      5'b00100: return 4'b0010;
      5'b00101, 5'b01101: return 4'b0011;
      5'b00110, 5'b01110: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [17:0] uop(int cls, int t);
    case (t)
      0: return SPcOut | SMarIn | SIncPc | SZIn;
      1: return SZlowOut | SPcIn | SRead | SMdrIn;
      2: return SMdrOut | SIrIn;
      3: return (cls <= ClsSt) ? (SGrb | SROut | SYIn) : 18'h0;
      4: return (cls == ClsReg) ? (SGrc | SROut | SZIn) : (SCOut | SZIn);
      5: return (cls == ClsLd || cls == ClsSt) ? (SZlowOut | SMarIn)
                                               : (SZlowOut | SGra | SRIn);
      6: return (cls == ClsLd) ? (SRead | SMdrIn) : (SGra | SROut | SMdrIn);
      default: return (cls == ClsLd) ? (SMdrOut | SGra | SRIn) : SWrite;
    endcase
  endfunction

  function automatic bit is_done(int cls, int t, bit mr);
    if (t == 3) return (cls == ClsHalt || cls == ClsBad);
    if (t == 5) return (cls == ClsReg || cls == ClsImm);
    if (t == 7) return (cls == ClsLd) || mr;
    return 1'b0;
  endfunction

  function automatic logic [34:0] model_out(logic [4:0] o, bit mr);
    int cls = cls_of(o);
    logic [7:0]  st = 8'h0;
    logic [17:0] s = 18'h0;
    logic [3:0]  a = 4'h0;
    bit b = 1'b0, d = 1'b0, il = 1'b0, h = 1'b0;
    if (m_mode == 1) begin
      st = 8'(1) << m_t;
      b  = 1'b1;
      s  = uop(cls, m_t);
      if (m_t == 1 && m_stall != 0) s = s & ~SPcIn;
      if (m_t == 4) a = alu_of(o);
      d  = is_done(cls, m_t, mr);
      il = (m_t == 3 && cls == ClsBad);
    end else if (m_mode == 2) begin
      h = 1'b1;
    end
    return {st, s, a, b, d, il, h, m_berr};
  endfunction

  task automatic model_step(bit r, logic [4:0] o, bit mr);
    int cls = cls_of(o);
    bit waiting;
    case (m_mode)
      0: if (r) begin m_mode = 1; m_t = 0; m_stall = 0; end
      1: begin
        waiting = (m_t == 1) || (m_t == 6 && cls == ClsLd) || (m_t == 7 && cls == ClsSt);
        if (m_t == 3 && cls == ClsHalt) begin
          m_mode = 2;
          m_stall = 0;
        end else if (waiting && !mr) begin
          m_stall++;
          if (m_stall == MemTimeout) begin
            m_berr = 1'b1;
            m_mode = 2;
            m_stall = 0;
          end
        end else if (is_done(cls, m_t, mr)) begin
          m_stall = 0;
          if (r) m_t = 0;
          else   m_mode = 0;
        end else begin
          m_t++;
          m_stall = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive(bit c, bit r, bit mr, logic [4:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c;
    run = r;
    mem_ready = mr;
    opc = o;
    cyc_cnt++;
    if (c) begin
      m_mode = 0; m_t = 0; m_stall = 0; m_berr = 1'b0;
    end
    e.vec = model_out(o, mr);
    e.phase = phase;
    e.cyc = 16'(cyc_cnt);
    sb_q.push_back(e);
    if (!c) model_step(r, o, mr);
  endtask

  task automatic drive_n(int n, bit c, bit r, bit mr, logic [4:0] o);
    for (int i = 0; i < n; i++) drive(c, r, mr, o);
  endtask

  function automatic logic [4:0] pick_opc();
    logic [4:0] tab [9] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                            5'b00110, 5'b01100, 5'b01101, 5'b01110};
    int k = $urandom_range(0, 99);
    if (k < 3)  return OpHalt;
    if (k < 10) return 5'($urandom_range(0, 31));
    return tab[$urandom_range(0, 8)];
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (dut_vec !== mon_e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b expected=%b", phase_name(mon_e.phase),
                 mon_e.cyc, dut_vec, mon_e.vec);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int halt_cnt;
    logic [4:0] opc_r;
    bit c, r, mr;

    phase = 8'd0;
    drive_n(3, 1, 0, 1, OpAdd);

    phase = 8'd1;
    drive_n(7, 0, 1, 1, OpAddi);        // IDLE, T0..T5, next T0

    phase = 8'd2;
    drive_n(1, 0, 1, 1, OpAdd);         // T1 entry is next
    drive_n(3, 0, 1, 0, OpAdd);
    drive_n(5, 0, 1, 1, OpAdd);

    phase = 8'd3;
    drive_n(6, 0, 1, 1, OpLd);
    drive_n(2, 0, 1, 0, OpLd);
    drive_n(2, 0, 1, 1, OpLd);

    phase = 8'd4;
    drive_n(7, 0, 1, 1, OpSt);
    drive_n(3, 0, 1, 0, OpSt);
    drive_n(1, 0, 1, 1, OpSt);

    phase = 8'd5;
    drive_n(5, 0, 1, 1, OpBad);

    phase = 8'd6;
    drive_n(3, 0, 1, 1, OpOr);
    drive_n(4, 0, 0, 1, OpOr);

    phase = 8'd7;
    drive_n(5, 0, 1, 1, OpHalt);
    drive_n(3, 0, 1, 1, OpHalt);

    phase = 8'd8;
    drive_n(1, 1, 0, 1, OpAdd);
    drive_n(2, 0, 1, 1, OpAdd);
    drive_n(18, 0, 1, 0, OpAdd);
    drive_n(3, 0, 1, 1, OpAdd);

    phase = 8'd9;
    drive_n(1, 1, 0, 1, OpAdd);
    drive_n(5, 0, 1, 1, OpAdd);
    drive_n(1, 1, 0, 1, OpAdd);
    drive_n(2, 0, 0, 1, OpAdd);

    phase = 8'd10;
    opc_r = OpAdd;
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(m_mode == 1 && m_t >= 3)) opc_r = pick_opc();
      if (m_mode == 2) halt_cnt++;
      else             halt_cnt = 0;
      c  = (halt_cnt > 2) || ($urandom_range(0, 199) == 0);
      r  = ($urandom_range(0, 9) != 0);
      mr = (i % 500 >= 478) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive(c, r, mr, opc_r);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
